// File: rtl/systolic_tile_sequencer.sv
// Systolic tile sequencer: CLEAR, then LOAD/FILL/CAPTURE/DRAIN per K-tile, then QUANT/OUTPUT; SEQ_QUANT_TIMEOUT_EN bounds QUANT.
// Latency: 1 + tiles*(ack_wait+1 + max(fill,1) + 1 + drain) + quant_wait+1 + out_wait+1 cycles; done one cycle after out_ready.
// Backpressure: stalls in LOAD on tile_ack, in QUANT on quant_valid, in OUTPUT on out_ready; start ignored while busy.
module systolic_tile_sequencer #(
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_tiles,
  input  logic [CNT_WIDTH-1:0] fill_cycles,
  input  logic [CNT_WIDTH-1:0] drain_cycles,
  input  logic [ACC_WIDTH-1:0] cfg_scale,
  input  logic [7:0]           cfg_shift,
  output logic                 tile_req,
  input  logic                 tile_ack,
  output logic                 enable,
  output logic                 accum_clear,
  output logic                 accum_enable,
  output logic                 quant_enable,
  output logic [ACC_WIDTH-1:0] scale_factor,
  output logic [7:0]           shift_amount,
  input  logic                 quant_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_FILL, S_CAPTURE, S_DRAIN, S_QUANT, S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] tiles_q, fill_q, drain_q;
  logic [CNT_WIDTH-1:0] cyc_cnt, tile_cnt;
  logic [CNT_WIDTH-1:0] tiles_eff, fill_last, drain_last;
  logic [CNT_WIDTH:0]   tile_cnt_inc;
  logic                 job_start, q_expired, q_timeout, job_end;

  assign job_start    = (state == S_IDLE) && start;
  assign tiles_eff    = (tiles_q == '0) ? CNT_WIDTH'(1) : tiles_q;
  assign fill_last    = (fill_q == '0) ? '0 : fill_q - CNT_WIDTH'(1);
  assign drain_last   = drain_q - CNT_WIDTH'(1);
  // One bit wider so the post-capture count cannot wrap when num_tiles is all ones.
  assign tile_cnt_inc = {1'b0, tile_cnt} + (CNT_WIDTH+1)'(1);
  assign q_timeout    = (state == S_QUANT) && !quant_valid && q_expired;
  assign job_end      = ((state == S_OUTPUT) && out_ready) || q_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_LOAD;
      S_LOAD:    if (tile_ack) state_nxt = S_FILL;
      S_FILL:    if (cyc_cnt == fill_last) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (drain_q != '0)                      state_nxt = S_DRAIN;
        else if (tile_cnt_inc < {1'b0, tiles_eff}) state_nxt = S_LOAD;
        else                                    state_nxt = S_QUANT;
      end
      S_DRAIN:   if (cyc_cnt == drain_last)
                   state_nxt = (tile_cnt < tiles_eff) ? S_LOAD : S_QUANT;
      S_QUANT: begin
        if (quant_valid)    state_nxt = S_OUTPUT;
        else if (q_expired) state_nxt = S_IDLE;
      end
      S_OUTPUT:  if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tile_req     = 1'b0;
    enable       = 1'b0;
    accum_clear  = 1'b0;
    accum_enable = 1'b0;
    quant_enable = 1'b0;
    out_valid    = 1'b0;
    unique case (state)
      S_CLEAR:   accum_clear = 1'b1;
      S_LOAD:    tile_req = 1'b1;
      S_FILL:    enable = 1'b1;
      S_CAPTURE: begin
        enable       = 1'b1;
        accum_enable = 1'b1;
      end
      S_QUANT:   quant_enable = 1'b1;
      S_OUTPUT: begin
        quant_enable = 1'b1;
        out_valid    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Job parameters are frozen at start so mid-job input changes cannot disturb the sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tiles_q      <= '0;
      fill_q       <= '0;
      drain_q      <= '0;
      scale_factor <= ACC_WIDTH'(1);
      shift_amount <= '0;
    end else if (job_start) begin
      tiles_q      <= num_tiles;
      fill_q       <= fill_cycles;
      drain_q      <= drain_cycles;
      scale_factor <= cfg_scale;
      shift_amount <= cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt  <= '0;
      tile_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= job_end;
      if (state_nxt != state)                       cyc_cnt <= '0;
      else if (state == S_FILL || state == S_DRAIN) cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
      if (job_start)               tile_cnt <= '0;
      else if (state == S_CAPTURE) tile_cnt <= tile_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef SEQ_QUANT_TIMEOUT_EN
  logic [8:0] q_cnt;
  logic       terr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_cnt  <= '0;
      terr_q <= 1'b0;
    end else begin
      q_cnt <= (state == S_QUANT) ? q_cnt + 9'd1 : 9'd0;
      if (job_start)      terr_q <= 1'b0;
      else if (q_timeout) terr_q <= 1'b1;
    end
  end

  // Index 255 is the 256th QUANT cycle.
  assign q_expired   = (q_cnt == 9'd255);
  assign timeout_err = terr_q;
`else
  assign q_expired   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
